// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, ALUOp encodings, R-type opcodes and
// the issue-buffer state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_ILL   = 4'b1111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_CBZ = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_BAD = 2'b11;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_TWO   = 2'b10
  } buf_state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: ALUOp plus R-type opcode to 4-bit ALU select.
// Purely combinational so other stages can reuse it.
module alu_ctrl_dec
  import alu_pkg::*;
#(
  parameter int OPC_W = 11
) (
  input  logic [1:0]       aluop,
  input  logic [OPC_W-1:0] opcode,
  output logic [3:0]       s,
  output logic             illegal
);

  always_comb begin
    s       = ALU_ILL;
    illegal = 1'b1;
    case (aluop)
      ALUOP_MEM: begin
        s       = ALU_ADD;
        illegal = 1'b0;
      end
      ALUOP_CBZ: begin
        s       = ALU_PASSB;
        illegal = 1'b0;
      end
      ALUOP_R: begin
        // Unlisted R-type opcodes fall through to the illegal default.
        if (opcode == OPC_W'(OPC_ADD)) begin
          s       = ALU_ADD;
          illegal = 1'b0;
        end else if (opcode == OPC_W'(OPC_SUB)) begin
          s       = ALU_SUB;
          illegal = 1'b0;
        end else if (opcode == OPC_W'(OPC_AND)) begin
          s       = ALU_AND;
          illegal = 1'b0;
        end else if (opcode == OPC_W'(OPC_ORR)) begin
          s       = ALU_ORR;
          illegal = 1'b0;
        end
      end
      default: begin
        s       = ALU_ILL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes the ALU select and feeds the ALU through a
// two-entry skid buffer. Define ALU_ISSUE_PERF_EN to add perf counters.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int OPC_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_aluop,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [3:0]        out_s,
  output logic              out_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_illegal
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        s;
    logic              ill;
  } op_t;

  // Stage p0: combinational decode of the incoming operation
  logic [3:0] dec_s_p0;
  logic       dec_ill_p0;
  op_t        op_p0;

  alu_ctrl_dec #(.OPC_W(OPC_W)) u_dec (
    .aluop   (in_aluop),
    .opcode  (in_opcode),
    .s       (dec_s_p0),
    .illegal (dec_ill_p0)
  );

  assign op_p0 = '{a: in_a, b: in_b, s: dec_s_p0, ill: dec_ill_p0};

  // Stage p1: main register m drives the ALU, skid register k absorbs a stall
  buf_state_e state_q, state_d;
  logic       in_ready_q;
  op_t        m_p1, k_p1;
  logic       accept, load_m, load_k, m_from_k;

  assign accept    = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != BUF_EMPTY);

  always_comb begin
    state_d  = state_q;
    load_m   = 1'b0;
    load_k   = 1'b0;
    m_from_k = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          state_d = BUF_ONE;
          load_m  = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && out_ready) begin
          load_m = 1'b1;
        end else if (accept) begin
          state_d = BUF_TWO;
          load_k  = 1'b1;
        end else if (out_ready) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (out_ready) begin
          state_d  = BUF_ONE;
          load_m   = 1'b1;
          m_from_k = 1'b1;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  // Ready is registered from next state, so out_ready never reaches in_ready
  // combinationally; it stays low through reset until the first clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b0;
      m_p1       <= '0;
      k_p1       <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != BUF_TWO);
      if (load_m) m_p1 <= m_from_k ? k_p1 : op_p0;
      if (load_k) k_p1 <= op_p0;
    end
  end

  assign out_a       = m_p1.a;
  assign out_b       = m_p1.b;
  assign out_s       = m_p1.s;
  assign out_illegal = m_p1.ill;

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued  <= '0;
      perf_illegal <= '0;
    end else if (out_valid && out_ready) begin
      perf_issued <= perf_issued + 32'd1;
      if (m_p1.ill) perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: decode table, directed buffer sequences
// and a randomized run against a queue-based reference model.
module tb_alu_issue;

  localparam logic [10:0] O_ADD = 11'b10001011000;
  localparam logic [10:0] O_SUB = 11'b11001011000;
  localparam logic [10:0] O_AND = 11'b10001010000;
  localparam logic [10:0] O_ORR = 11'b10101010000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [10:0] in_opcode;
  logic [63:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a, out_b;
  logic [3:0]  out_s;
  logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_illegal;
`endif

  alu_issue #(.DATA_W(64), .OPC_W(11)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_aluop    (in_aluop),
    .in_opcode   (in_opcode),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_s       (out_s),
    .out_illegal (out_illegal)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_illegal(perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  s;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [1:0]  aluop;
    logic [10:0] opc;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  s;
    logic        ill;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        mq[$];
  bit          armed;
  logic [31:0] iss_m, ill_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference select mapping, straight from the ALUOp/opcode table.
  function automatic logic [4:0] ref_sel(input logic [1:0] op, input logic [10:0] opc);
    if (op == 2'b00) return {1'b0, 4'b0010};
    if (op == 2'b01) return {1'b0, 4'b0111};
    if (op == 2'b10) begin
      if (opc == O_ADD) return {1'b0, 4'b0010};
      if (opc == O_SUB) return {1'b0, 4'b0110};
      if (opc == O_AND) return {1'b0, 4'b0000};
      if (opc == O_ORR) return {1'b0, 4'b0001};
    end
    return {1'b1, 4'b1111};
  endfunction

  // One clock: check DUT against the FIFO model, then advance the model.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [10:0] opc,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic ordy, output logic acc);
    logic       rdy_exp;
    logic [4:0] sel;
    exp_t       hd;
    in_valid  = v;
    in_aluop  = op;
    in_opcode = opc;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    rdy_exp = armed && (mq.size() < 2);
    chk("in_ready", {63'd0, in_ready}, {63'd0, rdy_exp});
    chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      hd = mq[0];
      chk("out_a", out_a, hd.a);
      chk("out_b", out_b, hd.b);
      chk("out_s", {60'd0, out_s}, {60'd0, hd.s});
      chk("out_illegal", {63'd0, out_illegal}, {63'd0, hd.ill});
    end
    acc = v && rdy_exp;
    if (mq.size() > 0 && ordy) begin
      hd = mq.pop_front();
      iss_m++;
      if (hd.ill) ill_m++;
    end
    if (acc) begin
      sel = ref_sel(op, opc);
      mq.push_back('{a: a, b: b, s: sel[3:0], ill: sel[4]});
    end
    @(posedge clk);
    #1;
    armed = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_a", out_a, 64'd0);
    chk("rst_out_b", out_b, 64'd0);
    chk("rst_out_s", {60'd0, out_s}, 64'd0);
    chk("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
    mq.delete();
    armed = 1'b0;
    iss_m = '0;
    ill_m = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        acc;
  vec_t        tbl[8];
  int          n;
  bit          held;
  logic [1:0]  r_op;
  logic [10:0] r_opc;
  logic [63:0] r_a, r_b;
  logic [63:0] bp_exp[3];

  initial begin
    tbl[0] = '{2'b00, 11'b00000000000, 64'd1, 64'd2, 4'b0010, 1'b0};
    tbl[1] = '{2'b01, O_ADD, 64'd3, 64'd4, 4'b0111, 1'b0};
    tbl[2] = '{2'b10, O_ADD, 64'd5, 64'd6, 4'b0010, 1'b0};
    tbl[3] = '{2'b10, O_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd8, 4'b0110, 1'b0};
    tbl[4] = '{2'b10, O_AND, 64'h8000_0000_0000_0000, 64'd9, 4'b0000, 1'b0};
    tbl[5] = '{2'b10, O_ORR, 64'd10, 64'hDEAD_BEEF_0000_0001, 4'b0001, 1'b0};
    tbl[6] = '{2'b10, 11'b11111111111, 64'd12, 64'd13, 4'b1111, 1'b1};
    tbl[7] = '{2'b11, O_ADD, 64'd14, 64'd15, 4'b1111, 1'b1};

    rst_n = 1'b0; in_valid = 0; in_aluop = 0; in_opcode = 0;
    in_a = 0; in_b = 0; out_ready = 0;
    armed = 0; iss_m = 0; ill_m = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // First cycle after reset release: ready still low
    cycle(1'b0, 2'b00, 11'd0, 64'd0, 64'd0, 1'b1, acc);

    // ADD stream
    cycle(1'b1, 2'b10, O_ADD, 64'd5, 64'd7, 1'b1, acc);
    chk("add_valid", {63'd0, out_valid}, 64'd1);
    chk("add_s", {60'd0, out_s}, 64'd2);
    chk("add_a", out_a, 64'd5);
    chk("add_b", out_b, 64'd7);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 2'b10, O_ADD, 64'(100 + i), 64'(i), 1'b1, acc);
      chk("stream_nobubble", {63'd0, out_valid}, 64'd1);
      chk("stream_a", out_a, 64'(100 + i));
    end

    // Decode sweep
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].aluop, tbl[i].opc, tbl[i].a, tbl[i].b, 1'b1, acc);
      chk("dec_valid", {63'd0, out_valid}, 64'd1);
      chk("dec_s", {60'd0, out_s}, {60'd0, tbl[i].s});
      chk("dec_ill", {63'd0, out_illegal}, {63'd0, tbl[i].ill});
      chk("dec_a", out_a, tbl[i].a);
      chk("dec_b", out_b, tbl[i].b);
    end
    cycle(1'b0, 2'b00, 11'd0, 64'd0, 64'd0, 1'b1, acc);

    // Backpressure: three ops offered with consumer stalled
    bp_exp[0] = 64'd11; bp_exp[1] = 64'd22; bp_exp[2] = 64'd33;
    cycle(1'b1, 2'b10, O_SUB, 64'd11, 64'd1, 1'b0, acc);
    cycle(1'b1, 2'b10, O_SUB, 64'd22, 64'd2, 1'b0, acc);
    chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
    chk("bp_head", out_a, bp_exp[0]);
    cycle(1'b1, 2'b10, O_SUB, 64'd33, 64'd3, 1'b0, acc);
    chk("bp_hold_head", out_a, bp_exp[0]);
    cycle(1'b1, 2'b10, O_SUB, 64'd33, 64'd3, 1'b1, acc);
    chk("bp_second", out_a, bp_exp[1]);
    cycle(1'b1, 2'b10, O_SUB, 64'd33, 64'd3, 1'b1, acc);
    chk("bp_third", out_a, bp_exp[2]);
    cycle(1'b0, 2'b00, 11'd0, 64'd0, 64'd0, 1'b1, acc);
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Randomized run with toggling out_ready
    n = 0;
    held = 0;
    r_op = 0; r_opc = 0; r_a = 0; r_b = 0;
    for (int cyc = 0; cyc < 6000 && n < 1000; cyc++) begin
      if (!held) begin
        r_op = 2'($urandom_range(3, 0));
        case ($urandom_range(4, 0))
          0: r_opc = O_ADD;
          1: r_opc = O_SUB;
          2: r_opc = O_AND;
          3: r_opc = O_ORR;
          default: r_opc = 11'($urandom);
        endcase
        r_a = {$urandom, $urandom};
        r_b = {$urandom, $urandom};
        held = 1;
      end
      cycle($urandom_range(3, 0) != 0, r_op, r_opc, r_a, r_b,
            $urandom_range(1, 0) == 1, acc);
      if (acc) begin
        n++;
        held = 0;
      end
    end
    chk("rand_ops_accepted", 64'(n), 64'd1000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 11'd0, 64'd0, 64'd0, 1'b1, acc);
    chk("rand_drained", {63'd0, out_valid}, 64'd0);

    // Reset while both entries are full
    cycle(1'b1, 2'b00, 11'd0, 64'd100, 64'd1, 1'b0, acc);
    cycle(1'b1, 2'b00, 11'd0, 64'd200, 64'd2, 1'b0, acc);
    chk("two_ready_low", {63'd0, in_ready}, 64'd0);
    do_reset();
    cycle(1'b0, 2'b00, 11'd0, 64'd0, 64'd0, 1'b0, acc);
    cycle(1'b1, 2'b01, 11'd0, 64'd300, 64'd3, 1'b1, acc);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_a", out_a, 64'd300);
    chk("post_rst_s", {60'd0, out_s}, 64'd7);
    cycle(1'b0, 2'b00, 11'd0, 64'd0, 64'd0, 1'b1, acc);
    chk("post_rst_alone", {63'd0, out_valid}, 64'd0);

`ifdef ALU_ISSUE_PERF_EN
    do_reset();
    cycle(1'b0, 2'b00, 11'd0, 64'd0, 64'd0, 1'b1, acc);
    for (int i = 0; i < 13; i++)
      cycle(1'b1, (i < 10) ? 2'b10 : 2'b11, O_ADD, 64'(i), 64'(i), 1'b1, acc);
    cycle(1'b0, 2'b00, 11'd0, 64'd0, 64'd0, 1'b1, acc);
    chk("perf_issued", {32'd0, perf_issued}, 64'd13);
    chk("perf_illegal", {32'd0, perf_illegal}, 64'd3);
    force dut.perf_issued = 32'hFFFF_FFFF;
    force dut.perf_illegal = 32'hFFFF_FFFF;
    #1;
    release dut.perf_issued;
    release dut.perf_illegal;
    cycle(1'b1, 2'b11, 11'd0, 64'd1, 64'd1, 1'b1, acc);
    cycle(1'b0, 2'b00, 11'd0, 64'd0, 64'd0, 1'b1, acc);
    chk("perf_issued_wrap", {32'd0, perf_issued}, 64'd0);
    chk("perf_illegal_wrap", {32'd0, perf_illegal}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Upstream issue stage for the 64-bit LEGv8 ALU. It accepts decoded instruction fields and two register operands over a valid/ready handshake, and translates ALUOp and opcode into the ALU's 4-bit select. It then presents registered operands and select to the combinational ALU through a two-entry skid buffer, so a stalled consumer never drops or duplicates an operation.

## Interface
Parameters:
- DATA_W, 64, operand width (must match the ALU's a/b/z width)
- OPC_W, 11, R-type opcode field width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous and active-low (assert asynchronously, deassert synchronous to clk externally)
- in_valid  input  1  upstream has an operation
- in_ready  output  1  stage can accept this cycle
- in_aluop  input  2  ALUOp from main decoder
- in_opcode  input  OPC_W  instruction bits [31:21]
- in_a  input  DATA_W  operand a (Rn)
- in_b  input  DATA_W  operand b (Rm or extended immediate)
- out_valid  output  1  a/b/s below are valid
- out_ready  input  1  consumer (ALU result register) accepts
- out_a  output  DATA_W  to ALU a
- out_b  output  DATA_W  to ALU b
- out_s  output  4  to ALU s
- out_illegal  output  1  decode found no legal mapping

## Operation
- Select decode (combinational on input side, then registered):
  - ALUOp 00 -> s=0010 (add; LDUR/STUR address)
  - ALUOp 01 -> s=0111 (pass b; CBZ)
  - ALUOp 10, opcode 10001011000 -> 0010 (ADD); 11001011000 -> 0110 (SUB); 10001010000 -> 0000 (AND); 10101010000 -> 0001 (ORR)
  - Any other ALUOp 10 opcode, or ALUOp 11 -> s=1111, out_illegal=1; operands still forwarded unchanged
- Buffer: main register M (drives outputs) plus skid register K. States EMPTY, ONE (M valid), TWO (M and K valid).
  - in_ready = (state != TWO), registered
  - out_valid = (state != EMPTY)
  - EMPTY: accept -> ONE (load M)
  - ONE: accept & out_ready -> ONE (load M); accept & !out_ready -> TWO (load K); !accept & out_ready -> EMPTY
  - TWO: out_ready -> ONE (M <= K); otherwise hold
- Order strictly FIFO; no reordering, no drops, no duplicates.
- Outputs held stable while out_valid & !out_ready.

## Timing
- Reset: state EMPTY; in_ready=0 during reset, 1 on first edge after; out_valid=0; out_a=0, out_b=0, out_s=0000, out_illegal=0; K cleared.
- Latency: accepted on edge N -> visible on out_* after edge N (one cycle) when buffer was EMPTY, or when ONE and out_ready was high.
- Throughput: one op per cycle with out_ready held high.
- in_ready depends only on registered state (no combinational out_ready->in_ready path).
- Simultaneous accept and drain in ONE: both happen; M replaced, no bubble.
- Reset mid-operation: contents of M and K discarded immediately; no partial outputs.

## Configuration
- ALU_ISSUE_PERF_EN: when defined, adds two 32-bit counters, perf_issued (increments on each out_valid & out_ready) and perf_illegal (increments on each drained op with out_illegal=1). Both are output ports, reset to 0, and wrap at 2^32. When undefined, the counters and ports are absent; all other behaviour is identical.

## Structure
- Shared package alu_pkg: ALU select constants (ALU_AND=0000, ALU_ORR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_PASSB=0111, ALU_NOR=1100, ALU_ILL=1111), ALUOp encodings, R-type opcode constants, buffer state typedef.
- One sub-module: alu_ctrl_dec (combinational ALUOp+opcode -> s, illegal), reusable by other stages.

## Test plan
- ADD stream: ALUOp 10, opcode 10001011000, a=5, b=7, out_ready=1 -> one cycle later out_s=0010, out_a=5, out_b=7, out_valid=1; 8 back-to-back ops drain with no bubbles.
- Decode sweep: ALUOp 00/01 and each R opcode -> s=0010/0111/0010/0110/0000/0001; ALUOp 10 opcode 11111111111 -> s=1111, out_illegal=1, operands forwarded.
- Backpressure: out_ready=0 while 3 ops offered -> ops 1, 2 accepted, in_ready=0 after second; release -> ops emerge in order 1, 2, 3, none lost.
- Simultaneous accept/drain in ONE with random out_ready toggling over 1000 ops -> scoreboard order and values exact.
- Reset asserted in TWO -> out_valid=0 and all outputs zero immediately; after release the first new op emerges alone.
- With ALU_ISSUE_PERF_EN: 10 legal + 3 illegal ops drained -> perf_issued=13, perf_illegal=3; preload near 2^32-1 (force) -> wraps to 0.
